// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between program_counter and decode.
// Issues single-outstanding word fetches, buffers returned words with their
// PC in a small prefetch queue, drives the PC stall and handles branch flushes
// (including dropping responses that were in flight when the flush hit).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pc_in               current PC from program_counter
//   flush               branch taken this cycle (also the PC branch_taken)
//   pc_stall            PC stall; 0 lets the PC advance at this edge
//   imem_req_*          fetch request port (valid/ready, addr = pc_in)
//   imem_rsp_*          fetch response (one per accepted request)
//   if_valid/if_instr/if_pc, id_ready   decode handshake on the queue head
module fetch_unit #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_in,
   input  logic        flush,
   output logic        pc_stall,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        id_ready
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0] DEPTH_M1_C = CW'(DEPTH - 1);
   localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RSP = 2'd1,
      DISCARD  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [31:0]     req_pc;
   logic [31:0]     q_pc    [DEPTH];
   logic [31:0]     q_instr [DEPTH];
   logic            accept;
   logic            push;
   logic            pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Request issue, PC control and next-state logic
   always_comb begin
      state_nxt      = state;
      imem_req_valid = 1'b0;

      case (state)
         IDLE:     imem_req_valid = !flush && (count < DEPTH_C);
         // A response this cycle frees the outstanding slot; keep room for
         // both the word arriving now and the one being requested.
         WAIT_RSP: imem_req_valid = !flush && imem_rsp_valid && (count < DEPTH_M1_C);
         default:  imem_req_valid = 1'b0;
      endcase
      if (!rst_n) imem_req_valid = 1'b0;

      accept   = imem_req_valid && imem_req_ready;
      pc_stall = !rst_n || !(accept || flush);

      case (state)
         IDLE: begin
            if (accept) state_nxt = WAIT_RSP;
         end
         WAIT_RSP: begin
            if (flush)               state_nxt = imem_rsp_valid ? IDLE : DISCARD;
            else if (imem_rsp_valid) state_nxt = accept ? WAIT_RSP : IDLE;
         end
         DISCARD: begin
            if (imem_rsp_valid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Queue handshake terms; flush suppresses both push and pop
   always_comb begin
      push      = !flush && (state == WAIT_RSP) && imem_rsp_valid;
      if_valid  = (count != '0) && !flush;
      pop       = if_valid && id_ready;
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   assign imem_req_addr = pc_in;
   assign if_instr      = q_instr[rd_ptr];
   assign if_pc         = q_pc[rd_ptr];

   // Prefetch queue, pointers and the PC of the outstanding request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         req_pc <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_pc[i]    <= '0;
            q_instr[i] <= '0;
         end
      end else begin
         if (accept) req_pc <= pc_in;
         if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) begin
               q_pc[wr_ptr]    <= req_pc;
               q_instr[wr_ptr] <= imem_rsp_data;
               wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count_nxt;
         end
      end
   end

   // A response with nothing outstanding is a memory-side protocol error
   always_ff @(posedge clk) begin
      if (rst_n && (state == IDLE)) assert (!imem_rsp_valid);
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a PC model and a single-outstanding memory
// model drive the DUT; directed scenarios push hand-computed (pc, instr) pairs
// into a queue that a monitor pops on every decode handshake.
module tb_fetch_unit;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc = 32'h0;
   logic        flush = 1'b0;
   logic [31:0] target = 32'h0;
   logic        pc_stall;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b1;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int delay = 0;
   logic [63:0] exp_q [$];

   fetch_unit #(.DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc_in          (pc),
      .flush          (flush),
      .pc_stall       (pc_stall),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .id_ready       (id_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [31:0] p);
      exp_q.push_back({p, p ^ KEY});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // PC model and memory model: sample at negedge, update 1 time unit after posedge
   logic        acc_s, stall_s, flush_s;
   logic [31:0] addr_s, tgt_s, pend_addr;
   int          pend = 0;
   int          wcnt = 0;
   always begin
      @(negedge clk);
      acc_s   = imem_req_valid && imem_req_ready;
      addr_s  = imem_req_addr;
      stall_s = pc_stall;
      flush_s = flush;
      tgt_s   = target;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         pc             = 32'h0;
         pend           = 0;
         imem_rsp_valid = 1'b0;
      end else begin
         if (flush_s)       pc = tgt_s;
         else if (!stall_s) pc = pc + 32'd4;
         imem_rsp_valid = 1'b0;
         if (acc_s) begin
            pend      = 1;
            pend_addr = addr_s;
            wcnt      = delay;
         end
         if (pend != 0) begin
            if (wcnt == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = pend_addr ^ KEY;
               pend           = 0;
            end else begin
               wcnt--;
            end
         end
      end
   end

   // Monitor: decode deliveries against the scoreboard, stall on request cycles
   always @(negedge clk) begin
      logic [63:0] e;
      if (rst_n) begin
         if (if_valid && id_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_delivery: actual pc=%h instr=%h required none", if_pc, if_instr);
            end else begin
               e = exp_q.pop_front();
               check("deliver_pc", if_pc, e[63:32]);
               check("deliver_instr", if_instr, e[31:0]);
            end
         end
         if (imem_req_valid && imem_req_ready)
            check("stall_on_accept", 32'(pc_stall), 32'd0);
         else if (imem_req_valid && !flush)
            check("stall_on_wait", 32'(pc_stall), 32'd1);
      end
   end

   task automatic do_reset(input int d, input logic rdy, input logic idr);
      tick();
      rst_n = 1'b0;
      flush = 1'b0;
      id_ready = 1'b0;
      tick();
      delay = d;
      imem_req_ready = rdy;
      id_ready = idr;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: actual remaining=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      id_ready = 1'b0;
   endtask

   // Waits (bounded) until a request for address a is accepted; returns at that negedge
   task automatic wait_acc(input logic [31:0] a, input int budget);
      int n = 0;
      bit found = 0;
      while (!found && n < budget) begin
         @(negedge clk);
         n++;
         if (imem_req_valid && imem_req_ready && imem_req_addr == a) found = 1;
      end
      if (!found) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_accept: actual no accept of %h required accept", a);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values (memory ready high, request must still be gated)
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_pc_stall", 32'(pc_stall), 32'd1);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_instr", if_instr, 32'h0);
      tick();
      rst_n = 1'b1;

      // Stream with zero-wait memory
      @(negedge clk);
      check("first_req_valid", 32'(imem_req_valid), 32'd1);
      check("first_req_addr", imem_req_addr, 32'h0);
      check("first_pc_stall", 32'(pc_stall), 32'd0);
      for (int i = 0; i < 8; i++) push_exp(32'(4 * i));
      tick();
      id_ready = 1'b1;
      drain(100);

      // Decode backpressure fills the queue with pc 0 and 4
      do_reset(0, 1'b1, 1'b0);
      repeat (10) tick();
      @(negedge clk);
      check("bp_if_valid", 32'(if_valid), 32'd1);
      check("bp_if_pc", if_pc, 32'h0);
      check("bp_if_instr", if_instr, 32'hA5A5_0000);
      check("bp_req_valid", 32'(imem_req_valid), 32'd0);
      check("bp_pc_stall", 32'(pc_stall), 32'd1);
      push_exp(32'h0);
      push_exp(32'h4);
      push_exp(32'h8);
      push_exp(32'hC);
      tick();
      id_ready = 1'b1;
      drain(100);

      // Memory wait states: ready low three cycles, response two cycles later
      do_reset(1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("ws_req_valid", 32'(imem_req_valid), 32'd1);
         check("ws_req_addr", imem_req_addr, 32'h0);
         check("ws_pc_stall", 32'(pc_stall), 32'd1);
      end
      tick();
      imem_req_ready = 1'b1;
      push_exp(32'h0);
      tick();
      imem_req_ready = 1'b0;
      drain(20);

      // Flush with the request for 0x8 in flight
      do_reset(2, 1'b1, 1'b1);
      push_exp(32'h0);
      push_exp(32'h4);
      push_exp(32'h100);
      push_exp(32'h104);
      push_exp(32'h108);
      wait_acc(32'h8, 60);
      tick();
      tick();
      flush = 1'b1;
      target = 32'h100;
      @(negedge clk);
      check("fl_if_valid", 32'(if_valid), 32'd0);
      check("fl_req_valid", 32'(imem_req_valid), 32'd0);
      check("fl_pc_stall", 32'(pc_stall), 32'd0);
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("discard_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      @(negedge clk);
      check("redirect_req_valid", 32'(imem_req_valid), 32'd1);
      check("redirect_req_addr", imem_req_addr, 32'h100);
      drain(100);

      // Flush coinciding with a response while the queue holds an entry
      do_reset(2, 1'b1, 1'b0);
      wait_acc(32'h4, 60);
      tick();
      tick();
      @(negedge clk);
      check("fq_pre_if_valid", 32'(if_valid), 32'd1);
      check("fq_pre_if_pc", if_pc, 32'h0);
      tick();
      flush = 1'b1;
      target = 32'h200;
      @(negedge clk);
      check("fq_if_valid", 32'(if_valid), 32'd0);
      check("fq_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("fq_post_if_valid", 32'(if_valid), 32'd0);
      check("fq_post_req_valid", 32'(imem_req_valid), 32'd1);
      check("fq_post_req_addr", imem_req_addr, 32'h200);
      push_exp(32'h200);
      push_exp(32'h204);
      tick();
      id_ready = 1'b1;
      drain(100);

      // Asynchronous reset mid-operation (WAIT_RSP with one entry queued)
      do_reset(2, 1'b1, 1'b0);
      wait_acc(32'h4, 60);
      tick();
      check("mid_pre_if_valid", 32'(if_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_if_valid", 32'(if_valid), 32'd0);
      check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("mid_rst_pc_stall", 32'(pc_stall), 32'd1);
      check("mid_rst_if_pc", if_pc, 32'h0);
      check("mid_rst_if_instr", if_instr, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rel_req_valid", 32'(imem_req_valid), 32'd1);
      check("mid_rel_req_addr", imem_req_addr, 32'h0);
      push_exp(32'h0);
      push_exp(32'h4);
      tick();
      id_ready = 1'b1;
      drain(100);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
